// File: rtl/seq_frame_ctrl.sv
// -----------------------------------------------------------------------------
// seq_frame_ctrl
//
// Sequencer in front of the bit-serial 01101 sequence detector. It accepts a
// parallel word and clears the detector. It then streams the word MSB-first on
// ser_din/ser_valid and keeps ser_valid high for a few drain cycles, so that
// the detector's registered seq_det output can still appear. Finally it reports
// how many detections it saw.
//
// Frame timeline (cycle 0 = cycle in which start is sampled in IDLE):
//   cycle 1                          : CLR   (det_clr pulse)
//   cycles 2 .. WORD_W+1             : SHIFT (one data bit per cycle)
//   next DRAIN_CYC cycles            : DRAIN (ser_din = PAD_BIT)
//   cycle WORD_W+DRAIN_CYC+2         : DONE  (done pulse)
//
// Parameters:
//   WORD_W     bits per frame (>= 2)
//   CNT_W      width of the saturating det_count
//   DRAIN_CYC  extra valid cycles after the last data bit (>= 1)
//   PAD_BIT    ser_din value driven during DRAIN
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begin a frame (only honoured in IDLE)
//   abort      in   cancel a frame in progress (wins over start)
//   din_word   in   frame data, captured when start is accepted
//   det_in     in   seq_det from the detector
//   det_clr    out  one-cycle clear pulse to the detector
//   ser_din    out  serial data to the detector
//   ser_valid  out  serial valid to the detector
//   busy       out  high from CLR through DONE
//   done       out  one-cycle frame-complete pulse
//   det_count  out  rising edges of det_in seen in the last/current frame
//
// Optional build macro SEQ_CTRL_HITPOS_EN adds:
//   last_hit_pos out [7:0]  valid-cycle index (0 = first SHIFT bit, counting
//                           on through DRAIN) of the most recent counted hit;
//                           8'hFF until the first hit of a frame.
//
// All outputs are registered: the next-state logic also computes the next
// output values, and these are then captured in the state register process.
// -----------------------------------------------------------------------------
module seq_frame_ctrl #(
    parameter int   WORD_W    = 16,
    parameter int   CNT_W     = 8,
    parameter int   DRAIN_CYC = 2,
    parameter logic PAD_BIT   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] din_word,
    input  logic              det_in,
    output logic              det_clr,
    output logic              ser_din,
    output logic              ser_valid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  det_count
`ifdef SEQ_CTRL_HITPOS_EN
    ,
    output logic [7:0]        last_hit_pos
`endif
);

    // One position counter spans SHIFT and DRAIN, so it doubles as the
    // valid-cycle index.
    localparam int POS_W = $clog2(WORD_W + DRAIN_CYC);
    localparam logic [POS_W-1:0] LAST_SHIFT = POS_W'(WORD_W - 1);
    localparam logic [POS_W-1:0] LAST_DRAIN = POS_W'(WORD_W + DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [WORD_W-1:0]   shreg;
    logic [POS_W-1:0]    pos;
    logic                det_prev;
    logic                accept;
    logic                in_stream;
    logic                hit;
    logic                det_clr_n;
    logic                ser_din_n;
    logic                ser_valid_n;
    logic                busy_n;
    logic                done_n;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign in_stream = (state == S_SHIFT) || (state == S_DRAIN);
    // A det_in level held over several cycles counts only once.
    assign hit       = in_stream && det_in && !det_prev;
    assign accept    = (state == S_IDLE) && (state_n == S_CLR);

    always_comb begin
        state_n     = state;
        det_clr_n   = 1'b0;
        ser_din_n   = 1'b0;
        ser_valid_n = 1'b0;
        busy_n      = 1'b0;
        done_n      = 1'b0;

        case (state)
            S_IDLE:  if (start && !abort) state_n = S_CLR;
            S_CLR:   state_n = S_SHIFT;
            S_SHIFT: if (pos == LAST_SHIFT) state_n = S_DRAIN;
            S_DRAIN: if (pos == LAST_DRAIN) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        if (abort && (state != S_IDLE)) begin
            state_n = S_IDLE;
        end

        // Outputs are decoded from the next state and registered below.
        case (state_n)
            S_CLR: begin
                det_clr_n = 1'b1;
                busy_n    = 1'b1;
            end
            S_SHIFT: begin
                ser_valid_n = 1'b1;
                ser_din_n   = shreg[WORD_W-1];
                busy_n      = 1'b1;
            end
            S_DRAIN: begin
                ser_valid_n = 1'b1;
                ser_din_n   = PAD_BIT;
                busy_n      = 1'b1;
            end
            S_DONE: begin
                done_n = 1'b1;
                busy_n = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            det_clr   <= 1'b0;
            ser_din   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            det_count <= '0;
            shreg     <= '0;
            pos       <= '0;
            det_prev  <= 1'b0;
        end else begin
            state     <= state_n;
            det_clr   <= det_clr_n;
            ser_din   <= ser_din_n;
            ser_valid <= ser_valid_n;
            busy      <= busy_n;
            done      <= done_n;

            // ser_din_n already took the MSB, so shift on every edge into SHIFT.
            if (accept) begin
                shreg <= din_word;
            end else if (state_n == S_SHIFT) begin
                shreg <= {shreg[WORD_W-2:0], 1'b0};
            end

            if (state == S_CLR) begin
                pos <= '0;
            end else if (in_stream) begin
                pos <= pos + POS_W'(1);
            end

            // Clearing in CLR makes a det_in already high at the first SHIFT
            // cycle count as a fresh edge.
            if (state == S_CLR) begin
                det_prev <= 1'b0;
            end else begin
                det_prev <= det_in;
            end

            if (accept) begin
                det_count <= '0;
            end else if (hit) begin
                det_count <= sat_inc(det_count);
            end
        end
    end

`ifdef SEQ_CTRL_HITPOS_EN
    logic [31:0] pos_ext;
    assign pos_ext = 32'(pos);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_hit_pos <= 8'hFF;
        end else if (accept) begin
            last_hit_pos <= 8'hFF;
        end else if (hit) begin
            last_hit_pos <= pos_ext[7:0];
        end
    end
`endif

endmodule
